// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for aes_core_multi and aes_round:
//   - key_len_e  : run-time key-length code (KL128, KL192, KL256, KL_RSVD)
//   - state_e    : core FSM states (IDLE, KEY_EXP, INIT, ROUND, DONE)
//   - SBOX/sbox  : forward S-box and a byte lookup helper
//   - rcon       : round-constant table
//   - nk_of/nr_of: key words / round count for a key-length code
//   - xtime/mixcolumn : GF(2^8) helpers for MixColumns
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [1:0] {
        KL128   = 2'd0,
        KL192   = 2'd1,
        KL256   = 2'd2,
        KL_RSVD = 2'd3
    } key_len_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        KEY_EXP = 3'd1,
        INIT    = 3'd2,
        ROUND   = 3'd3,
        DONE    = 3'd4
    } state_e;

    // Entry 0 sits in the top byte, so byte b lives at bits {~b,3'b111} -: 8.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Reserved code maps to the AES-128 sizes so downstream indexing stays
    // in range; the request itself is rejected before these are used.
    function automatic logic [3:0] nk_of(input key_len_e kl);
        case (kl)
            KL192:   return 4'd6;
            KL256:   return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input key_len_e kl);
        case (kl)
            KL192:   return 4'd12;
            KL256:   return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mixcolumn(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_round.sv
// ---------------------------------------------------------------------------
// aes_round
// One combinational AES encryption round:
//   SubBytes -> ShiftRows -> MixColumns (skipped when i_final) -> AddRoundKey
// Ports:
//   i_state [127:0] : current state, FIPS-197 byte order (byte 0 in 127:120)
//   i_rkey  [127:0] : round key for this round
//   i_final         : last round, MixColumns bypassed
//   o_state [127:0] : next state
// ---------------------------------------------------------------------------
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_rkey,
    input  logic         i_final,
    output logic [127:0] o_state
);

    logic [7:0]   w_sb [16];
    logic [7:0]   w_sr [16];
    logic [127:0] w_mc;
    logic [31:0]  w_col;

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            w_sb[k] = sbox(i_state[127-8*k -: 8]);
        end
        // Byte k is row k%4, column k/4; row r rotates left by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[r + 4*c] = w_sb[r + 4*((c + r) % 4)];
            end
        end
        w_mc  = '0;
        w_col = '0;
        for (int c = 0; c < 4; c++) begin
            w_col = {w_sr[4*c], w_sr[4*c+1], w_sr[4*c+2], w_sr[4*c+3]};
            w_mc[127-32*c -: 32] = i_final ? w_col : mixcolumn(w_col);
        end
        o_state = w_mc ^ i_rkey;
    end

endmodule

// File: rtl/aes_core_multi.sv
// ---------------------------------------------------------------------------
// aes_core_multi
// Iterative AES-128/192/256 encryption core. Key length chosen per request;
// the key schedule is expanded one word per cycle into a round-key store,
// then one full round is computed per cycle.
// Ports:
//   clk, rst (async, active-high)
//   i_valid / o_ready      : request handshake (o_ready only in IDLE)
//   i_key_len [1:0]        : 0=128, 1=192, 2=256, 3=reserved
//   i_key [MAX_KEY_BITS]   : key, left-aligned
//   i_plaintext [127:0]    : plaintext block
//   o_valid / i_ready      : result handshake, outputs held while stalled
//   o_ciphertext [127:0]   : result
//   o_err                  : one-cycle pulse on a rejected request
// Optional build macro AES_KEY_CACHE_EN: keep the last expanded key and skip
// key expansion when the next request uses the same key and length.
// ---------------------------------------------------------------------------
module aes_core_multi
    import aes_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [1:0]              i_key_len,
    input  logic [MAX_KEY_BITS-1:0] i_key,
    input  logic [127:0]            i_plaintext,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [127:0]            o_ciphertext,
    output logic                    o_err
);

    localparam int MAX_NR   = (MAX_KEY_BITS == 128) ? 10 :
                              (MAX_KEY_BITS == 192) ? 12 : 14;
    localparam int RK_WORDS = 4 * (MAX_NR + 1);

    state_e        r_fsm, w_fsm_nx;
    logic          r_err;
    logic [127:0]  r_state, r_ct;
    logic [31:0]   r_rk [RK_WORDS];
    logic [31:0]   r_kw [8];
    logic [5:0]    r_wi, r_wlast;
    logic [2:0]    r_kmod, r_nkm1;
    logic [3:0]    r_rci, r_round, r_nr;

    key_len_e      w_kl;
    logic [3:0]    w_nk, w_nr;
    logic [2:0]    w_nkm1;
    logic          w_illegal, w_ready, w_accept, w_hit, w_load, w_final;
    logic [255:0]  w_key_pad;
    logic [31:0]   w_kword [8];
    logic [31:0]   w_temp, w_newword;
    logic [5:0]    w_rk_base;
    logic [127:0]  w_rk, w_round_out;

    assign w_kl      = key_len_e'(i_key_len);
    assign w_nk      = nk_of(w_kl);
    assign w_nr      = nr_of(w_kl);
    assign w_nkm1    = 3'(w_nk - 4'd1);
    assign w_illegal = (w_kl == KL_RSVD) || ((32 * int'(w_nk)) > MAX_KEY_BITS);

    assign w_ready   = (r_fsm == IDLE) && !r_err;
    assign w_accept  = i_valid && w_ready;
    assign w_load    = w_accept && !w_illegal && !w_hit;
    assign w_final   = (r_round == r_nr);

    // Normalise the key to 256 bits, left-aligned, and split into words.
    assign w_key_pad = 256'(i_key) << (256 - MAX_KEY_BITS);

    always_comb begin
        for (int j = 0; j < 8; j++) begin
            w_kword[j] = w_key_pad[255-32*j -: 32];
        end
    end

    // r_kw[0] is w[i-1]; r_kw[Nk-1] is w[i-Nk].
    always_comb begin
        if (r_kmod == 3'd0) begin
            w_temp = subword({r_kw[0][23:0], r_kw[0][31:24]}) ^ {rcon(r_rci), 24'h0};
        end else if ((r_nkm1 == 3'd7) && (r_kmod == 3'd4)) begin
            w_temp = subword(r_kw[0]);
        end else begin
            w_temp = r_kw[0];
        end
        w_newword = r_kw[r_nkm1] ^ w_temp;
    end

    assign w_rk_base = {r_round, 2'b00};
    assign w_rk = {r_rk[w_rk_base], r_rk[w_rk_base + 6'd1],
                   r_rk[w_rk_base + 6'd2], r_rk[w_rk_base + 6'd3]};

    aes_round u_round (
        .i_state (r_state),
        .i_rkey  (w_rk),
        .i_final (w_final),
        .o_state (w_round_out)
    );

`ifdef AES_KEY_CACHE_EN
    logic                    r_cvalid;
    logic [1:0]              r_clen;
    logic [MAX_KEY_BITS-1:0] r_ckey;
    logic [255:0]            w_key_masked;
    logic [MAX_KEY_BITS-1:0] w_key_m;

    // Only the active key bits take part in the match.
    always_comb begin
        for (int j = 0; j < 8; j++) begin
            w_key_masked[255-32*j -: 32] = (4'(j) < w_nk) ? w_kword[j] : 32'h0;
        end
    end
    assign w_key_m = w_key_masked[255 -: MAX_KEY_BITS];
    assign w_hit   = r_cvalid && !w_illegal && (r_clen == i_key_len) && (r_ckey == w_key_m);

    // The store is overwritten on a miss, so the cache is invalid until the
    // new expansion finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cvalid <= 1'b0;
            r_clen   <= 2'd0;
            r_ckey   <= '0;
        end else if (w_load) begin
            r_cvalid <= 1'b0;
            r_clen   <= i_key_len;
            r_ckey   <= w_key_m;
        end else if ((r_fsm == KEY_EXP) && (r_wi == r_wlast)) begin
            r_cvalid <= 1'b1;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    // FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_nx;
        end
    end

    always_comb begin
        w_fsm_nx = r_fsm;
        case (r_fsm)
            IDLE: begin
                if (w_accept && !w_illegal) begin
                    w_fsm_nx = w_hit ? INIT : KEY_EXP;
                end
            end
            KEY_EXP: if (r_wi == r_wlast) w_fsm_nx = INIT;
            INIT:    w_fsm_nx = ROUND;
            ROUND:   if (w_final) w_fsm_nx = DONE;
            DONE:    if (i_ready) w_fsm_nx = IDLE;
            default: w_fsm_nx = IDLE;
        endcase
    end

    assign o_ready      = w_ready;
    assign o_valid      = (r_fsm == DONE);
    assign o_err        = r_err;
    assign o_ciphertext = r_ct;

    // Counters and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err   <= 1'b0;
            r_ct    <= '0;
            r_wi    <= '0;
            r_wlast <= '0;
            r_kmod  <= '0;
            r_nkm1  <= '0;
            r_rci   <= '0;
            r_round <= '0;
            r_nr    <= '0;
        end else begin
            r_err <= w_accept && w_illegal;
            if (w_accept && !w_illegal) begin
                r_nr    <= w_nr;
                r_nkm1  <= w_nkm1;
                r_wi    <= 6'(w_nk);
                r_wlast <= {w_nr, 2'b11};
                r_kmod  <= 3'd0;
                r_rci   <= 4'd1;
                r_round <= 4'd0;
            end else begin
                case (r_fsm)
                    KEY_EXP: begin
                        r_wi   <= r_wi + 6'd1;
                        r_kmod <= (r_kmod == r_nkm1) ? 3'd0 : r_kmod + 3'd1;
                        if (r_kmod == 3'd0) r_rci <= r_rci + 4'd1;
                    end
                    INIT:  r_round <= 4'd1;
                    ROUND: begin
                        if (w_final) r_ct <= w_round_out;
                        else         r_round <= r_round + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Datapath: cipher state, key window and round-key store
    always_ff @(posedge clk) begin
        if (w_accept && !w_illegal) begin
            r_state <= i_plaintext;
        end else if (r_fsm == INIT) begin
            r_state <= r_state ^ w_rk;
        end else if (r_fsm == ROUND) begin
            r_state <= w_round_out;
        end

        if (w_load) begin
            for (int j = 0; j < 8; j++) begin
                r_kw[j] <= (4'(j) < w_nk) ? w_kword[w_nkm1 - 3'(j)] : 32'h0;
                if (4'(j) < w_nk) r_rk[6'(j)] <= w_kword[j];
            end
        end else if (r_fsm == KEY_EXP) begin
            r_rk[r_wi] <= w_newword;
            r_kw[0]    <= w_newword;
            for (int j = 1; j < 8; j++) begin
                r_kw[j] <= r_kw[j-1];
            end
        end
    end

endmodule

// File: tb/tb_aes_core_multi.sv
// ---------------------------------------------------------------------------
// tb_aes_core_multi
// Directed bench for aes_core_multi (MAX_KEY_BITS = 256). Expected
// ciphertexts are FIPS-197 known answers queued when a request is driven
// and popped when o_valid appears. Latencies follow AES_KEY_CACHE_EN.
// ---------------------------------------------------------------------------
module tb_aes_core_multi;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic         o_ready;
    logic [1:0]   i_key_len;
    logic [255:0] i_key;
    logic [127:0] i_plaintext;
    logic         o_valid;
    logic         i_ready;
    logic [127:0] o_ciphertext;
    logic         o_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] sb_q [$];

`ifdef AES_KEY_CACHE_EN
    localparam bit CACHED = 1'b1;
`else
    localparam bit CACHED = 1'b0;
`endif
    localparam int L128H = CACHED ? 11 : 51;
    localparam int L192H = CACHED ? 13 : 59;
    localparam int L256H = CACHED ? 15 : 67;

    localparam logic [255:0] K128A = {128'h000102030405060708090a0b0c0d0e0f, 128'hdeadbeef_01234567_89abcdef_55aa55aa};
    localparam logic [255:0] K128B = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KAPB  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PTB   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CTB   = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_core_multi #(.MAX_KEY_BITS(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_key_len    (i_key_len),
        .i_key        (i_key),
        .i_plaintext  (i_plaintext),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_ciphertext (o_ciphertext),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0b, expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %032h, expected %032h", tag, obs, exp);
        end
    endtask

    task automatic checkint(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one request, measure latency, compare against the scoreboard,
    // optionally stall in DONE for hold cycles, then release.
    task automatic run_req(input string tag, input logic [255:0] key, input logic [1:0] klen,
                           input logic [127:0] pt, input logic [127:0] exp_ct,
                           input int exp_lat, input int hold, input bit early_ready);
        int n;
        logic [127:0] exp_q;
        i_key       = key;
        i_key_len   = klen;
        i_plaintext = pt;
        i_valid     = 1'b1;
        i_ready     = early_ready;
        check1({tag, "_ready_idle"}, o_ready, 1'b1);
        sb_q.push_back(exp_ct);
        @(posedge clk); #1;
        i_valid     = 1'b0;
        i_plaintext = '0;
        i_key       = '0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!o_valid && n < 300);
        checkint({tag, "_latency"}, n, exp_lat);
        check1({tag, "_valid"}, o_valid, 1'b1);
        exp_q = (sb_q.size() > 0) ? sb_q.pop_front() : 128'hx;
        check128({tag, "_ct"}, o_ciphertext, exp_q);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check1({tag, "_hold_valid"}, o_valid, 1'b1);
            check1({tag, "_hold_ready"}, o_ready, 1'b0);
            check128({tag, "_hold_ct"}, o_ciphertext, exp_q);
        end
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        check1({tag, "_post_valid"}, o_valid, 1'b0);
        check1({tag, "_post_ready"}, o_ready, 1'b1);
    endtask

    task automatic illegal_req(input string tag);
        int seen;
        i_key       = K128A;
        i_key_len   = 2'd3;
        i_plaintext = PT;
        i_valid     = 1'b1;
        check1({tag, "_ready"}, o_ready, 1'b1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        check1({tag, "_err_hi"}, o_err, 1'b1);
        check1({tag, "_no_valid"}, o_valid, 1'b0);
        @(posedge clk); #1;
        check1({tag, "_err_lo"}, o_err, 1'b0);
        check1({tag, "_ready_back"}, o_ready, 1'b1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (o_valid || o_err) seen++;
        end
        checkint({tag, "_quiet"}, seen, 0);
    endtask

    initial begin
        rst         = 1'b1;
        i_valid     = 1'b0;
        i_ready     = 1'b0;
        i_key_len   = 2'd0;
        i_key       = '0;
        i_plaintext = '0;
        repeat (2) @(posedge clk);
        #1;
        check1("rst_ready", o_ready, 1'b1);
        check1("rst_valid", o_valid, 1'b0);
        check1("rst_err", o_err, 1'b0);
        check128("rst_ct", o_ciphertext, 128'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_req("c1",  K128A, 2'd0, PT, CT128, 51, 0, 1'b0);
        run_req("c2",  K192,  2'd1, PT, CT192, 59, 0, 1'b1);
        run_req("c3",  K256,  2'd2, PT, CT256, 67, 0, 1'b0);
        run_req("bp",  K256,  2'd2, PT, CT256, L256H, 20, 1'b0);

        illegal_req("ill");

        // Abort a request partway through key expansion.
        i_key       = K128A;
        i_key_len   = 2'd0;
        i_plaintext = PT;
        i_valid     = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check1("arst_ready", o_ready, 1'b1);
        check1("arst_valid", o_valid, 1'b0);
        check1("arst_err", o_err, 1'b0);
        check128("arst_ct", o_ciphertext, 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_req("c1_after_rst", K128A, 2'd0, PT,  CT128, 51,    0, 1'b0);
        run_req("b_miss",       KAPB,  2'd0, PTB, CTB,   51,    0, 1'b0);
        run_req("b_hit",        KAPB,  2'd0, PTB, CTB,   L128H, 0, 1'b0);
        illegal_req("ill2");
        run_req("b_hit2",       KAPB,  2'd0, PTB, CTB,   L128H, 0, 1'b1);
        run_req("c1_miss",      K128B, 2'd0, PT,  CT128, 51,    0, 1'b0);
        run_req("c1_hit_lsb",   K128A, 2'd0, PT,  CT128, L128H, 0, 1'b0);
        run_req("c2_miss",      K192,  2'd1, PT,  CT192, 59,    0, 1'b0);
        run_req("c2_hit",       K192,  2'd1, PT,  CT192, L192H, 3, 1'b0);

        checkint("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_core_multi.md
Name: aes_core_multi

Overview:
- Iterative AES encryption core supporting AES-128, AES-192 and AES-256, with the key length selected per request at run time.
- The parameter MAX_KEY_BITS caps which key lengths are supported.
- Successor to the fixed AES-128 top: adds valid/ready handshakes on both sides, run-time key-length selection, and a stored key schedule.
- Sits between the host block-request interface and any downstream mode logic (CTR/CBC wrappers).

Parameters:
- MAX_KEY_BITS, 256, largest supported key length; legal values 128, 192, 256. Sets the i_key width and the round-key RAM depth (4*(Nr_max+1) words of 32 bits).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  request valid.
- o_ready  out  1  core can accept a request.
- i_key_len  in  2  0 = 128-bit key, 1 = 192-bit, 2 = 256-bit, 3 = reserved.
- i_key  in  MAX_KEY_BITS  key, left-aligned: key bits are i_key[MAX_KEY_BITS-1 -: keybits]; remaining LSBs are ignored.
- i_plaintext  in  128  plaintext block, FIPS-197 byte order (byte 0 in bits 127:120).
- o_valid  out  1  ciphertext valid.
- i_ready  in  1  downstream accepts the ciphertext.
- o_ciphertext  out  128  result.
- o_err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; o_ready=1, o_valid=0, o_err=0, o_ciphertext=0; round-key RAM contents are don't-care.
- A request is accepted on an edge where i_valid && o_ready. At that edge i_key, i_key_len and i_plaintext are captured.
- o_ready=1 only in IDLE.
- Key-length derivation: Nk = 4/6/8 and Nr = 10/12/14 for i_key_len 0/1/2.
- Illegal request: i_key_len=3, or keybits > MAX_KEY_BITS.
  - The request is consumed.
  - o_err=1 for exactly the next cycle, then the core returns to IDLE.
  - No o_valid is produced.
- State sequence:
  - IDLE: waits for accept, then goes to KEY_EXP.
  - KEY_EXP: words w[0..Nk-1] are loaded from the key at accept. One word w[i] is generated per cycle for i = Nk .. 4*(Nr+1)-1, using:
    - RotWord/SubWord/Rcon when i mod Nk = 0;
    - SubWord only when Nk = 8 and i mod 8 = 4;
    - plain XOR otherwise.
  - This takes W = 40/46/52 cycles.
  - INIT: state = plaintext XOR round key 0; 1 cycle.
  - ROUND: one full round per cycle: SubBytes, ShiftRows, MixColumns, AddRoundKey[r] for r = 1..Nr. MixColumns is omitted when r = Nr. Round counter is 4 bits.
  - DONE: o_valid=1 and o_ciphertext holds the final state. Both stay stable until i_ready is sampled high; that edge returns the core to IDLE.
- Latency: the first o_valid=1 cycle begins L edges after the accepting edge, where L = W+1+Nr = 51/59/67.
- Backpressure: in DONE with i_ready=0, all outputs are held indefinitely. i_valid is ignored while o_ready=0.
- i_ready asserted before DONE has no effect.
- Reset mid-operation aborts the request; no output is produced for it.

Optional Feature:
- Macro: AES_KEY_CACHE_EN.
- When defined:
  - The core stores the last fully expanded key plus its key length, and a cache-valid bit.
  - On accept, if the cache is valid and both key and length match, KEY_EXP is skipped: L = 1+Nr = 11/13/15.
  - Reset clears cache-valid.
  - A rejected request does not disturb the cache.
  - The cache becomes valid only when KEY_EXP completes; a reset during KEY_EXP leaves it invalid.
- When undefined: every request performs KEY_EXP; no extra storage is built.

Decomposition:
- aes_pkg holds:
  - the S-box constant and the Rcon table;
  - a key_len_e enum (KL128, KL192, KL256, KL_RSVD);
  - functions nk_of and nr_of;
  - xtime and mixcolumn functions;
  - the state enum (IDLE, KEY_EXP, INIT, ROUND, DONE).
- One sub-module, aes_round: combinational; inputs are state, round key and a final flag; output is the next state.
- The key schedule and FSM remain in aes_core_multi.

Test Plan:
1. AES-128 (FIPS-197 C.1): key 000102030405060708090a0b0c0d0e0f (left-aligned), pt 00112233445566778899aabbccddeeff -> o_valid 51 edges after accept, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
2. AES-192 (C.2): key 000102…1617, same pt -> ct dda97ca4864cdfe06eaf70a0ec0d7191 at L=59.
3. AES-256 (C.3): key 000102…1e1f, same pt -> ct 8ea2b7ca516745bfeafc49904b496089 at L=67.
4. Backpressure: hold i_ready=0 for 20 cycles in DONE -> o_valid and o_ciphertext stable, o_ready=0. Raise i_ready -> next cycle o_ready=1, o_valid=0.
5. i_key_len=3 request -> o_err high for exactly 1 cycle, no o_valid, o_ready back to 1. Assert rst during KEY_EXP -> outputs reset immediately; a following C.1 request still produces the correct ct.
6. AES_KEY_CACHE_EN: request with Appendix B key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32 at L=51. Repeat the same key with the C.1 pt -> a correctly matching ct at L=11.
